// File: rtl/buffer_stream_ctrl.sv
// Valid/ready FWFT FIFO controller around one registered-read buffer plus a 2-word output skid.
// Push-to-out_valid latency 3 cycles; in_ready drops only when the buffer itself is full.
module buffer_stream_ctrl #(
    parameter int addrLen = 6,
    parameter int dataLen = 32,
    parameter int memSize = 1 << addrLen
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [dataLen-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [dataLen-1:0] out_data,
    output logic               buf_wrt,
    output logic [addrLen-1:0] buf_wrt_addr,
    output logic [addrLen-1:0] buf_rd_addr,
    output logic [dataLen-1:0] buf_data_in,
    input  logic [dataLen-1:0] buf_data_out,
    output logic [addrLen+1:0] level
);

    localparam logic [addrLen:0] MEM_FULL = (addrLen+1)'(memSize);

    logic [addrLen:0]   wr_ptr;
    logic [addrLen:0]   rd_ptr;
    logic [addrLen:0]   mem_cnt;
    logic [addrLen-1:0] rd_addr_q;
    logic               inflight;
    logic [1:0]         skid_cnt;
    logic [dataLen-1:0] skid_q0;
    logic [dataLen-1:0] skid_q1;
    logic [2:0]         skid_held;
    logic               push;
    logic               pop;
    logic               rd_issue;

    assign mem_cnt   = wr_ptr - rd_ptr;
    assign in_ready  = reset && (mem_cnt != MEM_FULL);
    assign push      = in_valid && in_ready;
    assign out_valid = (skid_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = skid_q0;

    // Counting the current pop as freed space keeps a full skid streaming at one word per cycle.
    assign skid_held = {1'b0, skid_cnt} + {2'b00, inflight};
    assign rd_issue  = (mem_cnt != '0) && ((skid_held - {2'b00, pop}) < 3'd2);

    assign buf_wrt      = push;
    assign buf_wrt_addr = wr_ptr[addrLen-1:0];
    assign buf_rd_addr  = rd_issue ? rd_ptr[addrLen-1:0] : rd_addr_q;
    assign buf_data_in  = in_data;

    assign level = {1'b0, mem_cnt} + (addrLen+2)'(skid_cnt) + (addrLen+2)'(inflight);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_addr_q <= '0;
            inflight  <= 1'b0;
            skid_cnt  <= 2'd0;
            skid_q0   <= '0;
            skid_q1   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_addr_q <= rd_ptr[addrLen-1:0];
            end
            inflight <= rd_issue;
            // inflight means buf_data_out carries the word read last cycle.
            case ({pop, inflight})
                2'b10: begin
                    skid_q0  <= skid_q1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b01: begin
                    if (skid_cnt == 2'd0) begin
                        skid_q0 <= buf_data_out;
                    end else begin
                        skid_q1 <= buf_data_out;
                    end
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid_q0 <= buf_data_out;
                    end else begin
                        skid_q0 <= skid_q1;
                        skid_q1 <= buf_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_stream_ctrl.sv
// Directed bench for buffer_stream_ctrl with a registered-read RAM model attached.
module tb_buffer_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        buf_wrt;
    logic [5:0]  buf_wrt_addr;
    logic [5:0]  buf_rd_addr;
    logic [31:0] buf_data_in;
    logic [31:0] buf_data_out;
    logic [7:0]  level;

    logic [31:0] mem [64];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (buf_wrt) mem[buf_wrt_addr] <= buf_data_in;
        buf_data_out <= mem[buf_rd_addr];
    end

    buffer_stream_ctrl #(.addrLen(6), .dataLen(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .buf_wrt(buf_wrt), .buf_wrt_addr(buf_wrt_addr), .buf_rd_addr(buf_rd_addr),
        .buf_data_in(buf_data_in), .buf_data_out(buf_data_out), .level(level)
    );

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (level !== 8'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
        tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        reset = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        drive(1'b1, 32'hA5A5_0001, 1'b0);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_accept got %b want 1", in_ready); end
        drive(1'b0, 32'h0, 1'b0);
        tests++; if (out_valid !== 1'b0 || level !== 8'd1) begin fails++; $display("FAIL lat_t1 got vld %b lvl %0d want 0 1", out_valid, level); end
        drive(1'b0, 32'h0, 1'b0);
        tests++; if (out_valid !== 1'b0 || level !== 8'd1) begin fails++; $display("FAIL lat_t2 got vld %b lvl %0d want 0 1", out_valid, level); end
        drive(1'b0, 32'h0, 1'b1);
        tests++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || level !== 8'd1) begin
            fails++; $display("FAIL lat_t3 got vld %b dat %h lvl %0d want 1 a5a50001 1", out_valid, out_data, level); end
        drive(1'b0, 32'h0, 1'b0);
        tests++; if (out_valid !== 1'b0 || level !== 8'd0) begin fails++; $display("FAIL lat_pop got vld %b lvl %0d want 0 0", out_valid, level); end
    endtask

    task automatic test_fill();
        int accepted = 0;
        for (int c = 0; c < 80; c++) begin
            drive(1'b1, 32'(accepted + 1), 1'b0);
            if (in_ready) accepted++;
        end
        tests++; if (accepted != 66) begin fails++; $display("FAIL fill_count got %0d want 66", accepted); end
        drive(1'b1, 32'd67, 1'b0);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_stall got %b want 0", in_ready); end
        tests++; if (level !== 8'd66) begin fails++; $display("FAIL fill_level got %0d want 66", level); end
        tests++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin fails++; $display("FAIL fill_head got %b %h want 1 1", out_valid, out_data); end
    endtask

    task automatic test_drain();
        int pops = 0;
        int bad = 0;
        for (int i = 1; i <= 66; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            if (out_valid === 1'b1) pops++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                bad++;
                $display("FAIL drain_word%0d got vld %b dat %0d want 1 %0d", i, out_valid, out_data, i);
            end
        end
        tests++; if (bad != 0) fails++;
        tests++; if (pops != 66) begin fails++; $display("FAIL drain_pops got %0d want 66", pops); end
        drive(1'b0, 32'h0, 1'b1);
        tests++; if (out_valid !== 1'b0 || level !== 8'd0) begin fails++; $display("FAIL drain_empty got vld %b lvl %0d want 0 0", out_valid, level); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL drain_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_d;
        logic [31:0] prev_dat = '0;
        logic        prev_hold = 1'b0;
        logic        v, r;
        int pushes = 0, pops = 0, cyc = 0, bad = 0;
        reset_dut();
        while (pops < 10000 && cyc < 60000) begin
            v = (pushes < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 1'($urandom_range(0, 1));
            drive(v, $urandom, r);
            cyc++;
            if (level !== 8'(pushes - pops)) begin
                bad++;
                if (bad < 10) $display("FAIL rnd_level cyc %0d got %0d want %0d", cyc, level, pushes - pops);
            end
            if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_dat)) begin
                bad++;
                if (bad < 10) $display("FAIL rnd_hold cyc %0d got %b %h want 1 %h", cyc, out_valid, out_data, prev_dat);
            end
            if (v && in_ready) begin q.push_back(in_data); pushes++; end
            if (out_valid && r) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 32'hDEAD_DEAD;
                if (out_data !== exp_d) begin
                    bad++;
                    if (bad < 10) $display("FAIL rnd_data pop %0d got %h want %h", pops, out_data, exp_d);
                end
                pops++;
            end
            prev_hold = out_valid && !r;
            prev_dat  = out_data;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL rnd_errors got %0d want 0", bad); end
        tests++; if (pops != 10000 || q.size() != 0) begin fails++; $display("FAIL rnd_pops got %0d left %0d want 10000 0", pops, q.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        logic [31:0] exp_d;
        logic [5:0]  exp_wa = '0;
        logic        v;
        int pushes = 0, pops = 0, cyc = 0, wraps = 0, bad = 0;
        reset_dut();
        while (pops < 200 && cyc < 400) begin
            v = (pushes < 200);
            drive(v, 32'h5000_0000 + 32'(pushes), 1'b1);
            cyc++;
            if (buf_wrt) begin
                if (buf_wrt_addr !== exp_wa) begin
                    bad++; $display("FAIL wrap_waddr got %0d want %0d", buf_wrt_addr, exp_wa);
                end
                if (exp_wa == 6'd63) wraps++;
                exp_wa = exp_wa + 6'd1;
            end
            if (v && in_ready) begin q.push_back(in_data); pushes++; end
            if (out_valid) begin
                exp_d = (q.size() > 0) ? q.pop_front() : 32'hDEAD_DEAD;
                if (out_data !== exp_d) begin
                    bad++; $display("FAIL wrap_data pop %0d got %h want %h", pops, out_data, exp_d);
                end
                pops++;
            end
        end
        tests++; if (bad != 0) fails++;
        tests++; if (wraps != 3) begin fails++; $display("FAIL wrap_count got %0d want 3", wraps); end
        tests++; if (pops != 200 || cyc > 205) begin fails++; $display("FAIL wrap_rate got pops %0d cycles %0d want 200 <=205", pops, cyc); end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h7700_0000 + 32'(i), 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        tests++; if (level !== 8'd10) begin fails++; $display("FAIL mid_level_before got %0d want 10", level); end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0 || level !== 8'd0) begin fails++; $display("FAIL mid_cleared got vld %b lvl %0d want 0 0", out_valid, level); end
        reset = 1'b1;
        in_valid = 1'b1; in_data = 32'hBEEF_0006;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_accept got %b want 1", in_ready); end
        drive(1'b0, 32'h0, 1'b0);
        tests++; if (out_valid !== 1'b0 || level !== 8'd1) begin fails++; $display("FAIL mid_t1 got vld %b lvl %0d want 0 1", out_valid, level); end
        drive(1'b0, 32'h0, 1'b0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_t2 got %b want 0", out_valid); end
        drive(1'b0, 32'h0, 1'b1);
        tests++; if (out_valid !== 1'b1 || out_data !== 32'hBEEF_0006) begin
            fails++; $display("FAIL mid_t3 got vld %b dat %h want 1 beef0006", out_valid, out_data); end
        drive(1'b0, 32'h0, 1'b0);
        tests++; if (out_valid !== 1'b0 || level !== 8'd0) begin fails++; $display("FAIL mid_after got vld %b lvl %0d want 0 0", out_valid, level); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_drain();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
